parity_frame_rx: RTL

- Serial receiver for parity-protected frames: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1).
- Deserialises one bit per bit_en strobe and checks parity with an XNOR/XOR reduction.
- Presents each byte on a valid/ready output port, with parity, framing and overrun status.
- Receive end of the team's serial parity link, consuming the line driven by the parity frame transmitter.

---
 rtl/parity_frame_rx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/parity_frame_rx.sv
// Serial parity-frame receiver: start(0), DATA_W bits LSB first, parity, stop(1), with a valid/ready output.
// Optional error counter is built when PARITY_RX_ERR_CNT_EN is defined; otherwise err_cnt is tied to 0.
module parity_frame_rx #(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              rx_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_par;
    logic              r_pbit;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_parity_err;
    logic              r_frame_err;
    logic              r_overrun;
    logic              w_done;
    logic              w_drop;
    logic              w_load;
    logic              w_par_err;
    logic              w_frame_err;

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] s, input logic b);
        logic [DATA_W-1:0] r;
        r = s >> 1;
        r[DATA_W-1] = b;
        return r;
    endfunction

    function automatic logic parity_ok(input logic p, input logic pb);
        if (ODD_PARITY != 0) return p ^ pb;
        else                 return ~(p ^ pb);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        if (bit_en) begin
            case (r_state)
                S_IDLE:   if (!rx_in) w_next = S_DATA;
                S_DATA:   if (r_cnt == CNT_W'(DATA_W - 1)) w_next = S_PARITY;
                S_PARITY: w_next = S_STOP;
                S_STOP: begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end
                default:  w_next = S_IDLE;
            endcase
        end
    end

    assign w_par_err   = ~parity_ok(r_par, r_pbit);
    assign w_frame_err = ~rx_in;
    // A completed frame is dropped only when the held one cannot leave on this edge.
    assign w_drop      = w_done & r_out_valid & ~out_ready;
    assign w_load      = w_done & ~w_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_pbit  <= 1'b0;
        end else if (bit_en) begin
            case (r_state)
                S_IDLE: if (!rx_in) begin
                    r_cnt <= '0;
                    r_par <= 1'b0;
                end
                S_DATA: begin
                    r_shift <= shift_in(r_shift, rx_in);
                    r_par   <= r_par ^ rx_in;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                S_PARITY: r_pbit <= rx_in;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            if (w_load) begin
                r_out_data   <= r_shift;
                r_parity_err <= w_par_err;
                r_frame_err  <= w_frame_err;
                r_out_valid  <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef PARITY_RX_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_err_cnt <= 8'h00;
        else if (((w_load && (w_par_err || w_frame_err)) || w_drop) && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'h01;
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'h00;
`endif

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);

endmodule
